// File: rtl/player_ctrl_gen_if.sv
// Control/status bundle between the beat sequencer and its host.
// The host drives transport controls; the sequencer returns beat index and status.
interface player_ctrl_gen_if #(
  parameter int BEAT_W = 8
);
  logic              beat_en;
  logic              run;
  logic              dir;
  logic              loop;
  logic              restart;
  logic [BEAT_W-1:0] ibeat;
  logic              playing;
  logic              done;
  logic              wrap;
  logic [1:0]        state;

  modport master (
    output beat_en, run, dir, loop, restart,
    input  ibeat, playing, done, wrap, state
  );

  modport slave (
    input  beat_en, run, dir, loop, restart,
    output ibeat, playing, done, wrap, state
  );
endinterface

// File: rtl/player_ctrl_gen.sv
// Beat sequencer: steps ibeat over 0..LAST_BEAT on beat strobes,
// forward or reverse, with play/pause, loop/one-shot and restart.
module player_ctrl_gen #(
  parameter int BEAT_W    = 8,
  parameter int LAST_BEAT = 28
) (
  input logic              clk,
  input logic              reset,
  player_ctrl_gen_if.slave bus
);

  typedef enum logic [1:0] {
    STOP  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [BEAT_W-1:0] LB = BEAT_W'(LAST_BEAT);
  localparam logic [BEAT_W-1:0] ZB = '0;

  state_t            state_q, state_d;
  logic [BEAT_W-1:0] ibeat_q, ibeat_d;
  logic              wrap_q, wrap_d;
  logic              at_end;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= STOP;
      ibeat_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ibeat_q <= ibeat_d;
      wrap_q  <= wrap_d;
    end
  end

  // End reached in the current direction; compare before stepping
  // so the counter never overflows when LAST_BEAT is all ones.
  assign at_end = bus.dir ? (ibeat_q == ZB) : (ibeat_q == LB);

  always_comb begin
    state_d = state_q;
    ibeat_d = ibeat_q;
    wrap_d  = 1'b0;
    if (bus.restart) begin
      ibeat_d = bus.dir ? LB : ZB;
      state_d = bus.run ? PLAY : STOP;
    end else begin
      unique case (state_q)
        STOP, PAUSE: begin
          if (bus.run) state_d = PLAY;
        end
        PLAY: begin
          if (!bus.run) begin
            state_d = PAUSE;
          end else if (bus.beat_en) begin
            unique case (1'b1)
              !at_end: ibeat_d = bus.dir ? ibeat_q - 1'b1
                                         : ibeat_q + 1'b1;
              at_end && bus.loop: begin
                ibeat_d = bus.dir ? LB : ZB;
                wrap_d  = 1'b1;
              end
              default: state_d = DONE;
            endcase
          end
        end
        DONE: begin
          // Leave only when dir now points away from the held end
          if (bus.run && !at_end) state_d = PLAY;
        end
        default: state_d = STOP;
      endcase
    end
  end

  assign bus.ibeat   = ibeat_q;
  assign bus.state   = state_q;
  assign bus.playing = (state_q == PLAY);
  assign bus.done    = (state_q == DONE);
  assign bus.wrap    = wrap_q;

endmodule

// File: tb/tb_player_ctrl_gen.sv
// Directed bench for player_ctrl_gen: default 0..28 instance
// plus a BEAT_W=3 / LAST_BEAT=7 instance for the wrap boundary.
module tb_player_ctrl_gen;

  logic clk = 1'b0;
  logic reset_a = 1'b1;
  logic reset_b = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  player_ctrl_gen_if #(.BEAT_W(8)) a_if ();
  player_ctrl_gen_if #(.BEAT_W(3)) b_if ();

  player_ctrl_gen #(.BEAT_W(8), .LAST_BEAT(28)) dut_a (
    .clk  (clk),
    .reset(reset_a),
    .bus  (a_if.slave)
  );

  player_ctrl_gen #(.BEAT_W(3), .LAST_BEAT(7)) dut_b (
    .clk  (clk),
    .reset(reset_b),
    .bus  (b_if.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_a(input string tag, input int beat, input int st);
    chk({tag, ".ibeat"}, 32'(a_if.ibeat), 32'(beat));
    chk({tag, ".state"}, 32'(a_if.state), 32'(st));
    chk({tag, ".playing"}, 32'(a_if.playing), 32'(st == 1));
    chk({tag, ".done"}, 32'(a_if.done), 32'(st == 3));
  endtask

  task automatic strobe4();
    a_if.beat_en = 1'b1;
    tick();
    a_if.beat_en = 1'b0;
    tick();
    tick();
    tick();
  endtask

  initial begin
    int exp_b;
    int wraps;
    a_if.beat_en = 0; a_if.run = 0; a_if.dir = 0;
    a_if.loop = 0; a_if.restart = 0;
    b_if.beat_en = 0; b_if.run = 0; b_if.dir = 0;
    b_if.loop = 0; b_if.restart = 0;
    tick();
    tick();
    chk_a("reset", 0, 0);
    chk("reset.wrap", 32'(a_if.wrap), 0);
    reset_a = 1'b0;

    // forward one-shot, strobe every 4 cycles
    a_if.run = 1;
    tick();
    chk_a("start", 0, 1);
    for (int i = 1; i <= 28; i++) begin
      strobe4();
      chk("fwd.ibeat", 32'(a_if.ibeat), 32'(i));
    end
    chk_a("fwd28", 28, 1);
    strobe4();
    chk_a("fwd.done", 28, 3);
    strobe4();
    chk_a("fwd.done.hold", 28, 3);

    // dir away from held end leaves DONE without stepping
    a_if.dir = 1;
    tick();
    chk_a("done.exit", 28, 1);
    a_if.dir = 0; a_if.loop = 1; a_if.beat_en = 1;
    tick();
    chk_a("fwd.wrap", 0, 1);
    chk("fwd.wrap.pulse", 32'(a_if.wrap), 1);
    a_if.beat_en = 0;
    tick();
    chk("fwd.wrap.clear", 32'(a_if.wrap), 0);
    chk("fwd.wrap.hold", 32'(a_if.ibeat), 0);

    // reverse, back-to-back strobes
    a_if.dir = 1; a_if.loop = 0; a_if.restart = 1;
    tick();
    a_if.restart = 0;
    chk_a("rev.restart", 28, 1);
    a_if.beat_en = 1;
    for (int i = 1; i <= 28; i++) begin
      tick();
      chk("rev.ibeat", 32'(28 - i), 32'(a_if.ibeat));
    end
    tick();
    chk_a("rev.done", 0, 3);
    chk("rev.nowrap", 32'(a_if.wrap), 0);
    a_if.beat_en = 0; a_if.dir = 0;
    tick();
    chk_a("rev.exit", 0, 1);
    a_if.beat_en = 1;
    tick();
    a_if.beat_en = 0;
    chk_a("rev.exit.step", 1, 1);

    // pause at 10
    for (int i = 0; i < 9; i++) strobe4();
    chk("pause.pre", 32'(a_if.ibeat), 10);
    a_if.run = 0; a_if.beat_en = 1;
    tick();
    a_if.beat_en = 0;
    chk_a("pause", 10, 2);
    tick();
    chk_a("pause.hold", 10, 2);
    a_if.run = 1;
    tick();
    chk_a("resume", 10, 1);
    tick();
    chk_a("resume.nostep", 10, 1);
    strobe4();
    chk_a("resume.step", 11, 1);

    // restart beats a simultaneous strobe
    for (int i = 0; i < 4; i++) strobe4();
    chk("rst.pre", 32'(a_if.ibeat), 15);
    a_if.restart = 1; a_if.beat_en = 1;
    tick();
    a_if.restart = 0; a_if.beat_en = 0;
    chk_a("restart.strobe", 0, 1);

    // reset mid-play
    for (int i = 0; i < 20; i++) strobe4();
    chk("reset.pre", 32'(a_if.ibeat), 20);
    reset_a = 1; a_if.beat_en = 1;
    tick();
    reset_a = 0; a_if.beat_en = 0;
    chk_a("reset.mid", 0, 0);

    // reverse loop wrap from 0
    tick();
    chk_a("rev.loop.pre", 0, 1);
    a_if.dir = 1; a_if.loop = 1; a_if.beat_en = 1;
    tick();
    a_if.beat_en = 0;
    chk_a("rev.loop", 28, 1);
    chk("rev.loop.wrap", 32'(a_if.wrap), 1);

    // 3-bit instance: 0..7,0 with one wrap per period
    tick();
    chk("b.reset", 32'(b_if.ibeat), 0);
    reset_b = 0;
    b_if.run = 1; b_if.loop = 1;
    tick();
    chk("b.start", 32'(b_if.state), 1);
    b_if.beat_en = 1;
    exp_b = 0;
    wraps = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      exp_b = (exp_b == 7) ? 0 : exp_b + 1;
      chk("b.ibeat", 32'(b_if.ibeat), 32'(exp_b));
      chk("b.wrap", 32'(b_if.wrap), 32'(exp_b == 0));
      if (b_if.wrap) wraps++;
    end
    chk("b.wraps", 32'(wraps), 2);
    b_if.beat_en = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
